// File: rtl/main_memory_burst_pkg.sv
// Shared types and helpers for the burst main memory: FSM state encoding,
// default widths and burst-length clamping.
package main_memory_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        RD,
        WR,
        FIN
    } mem_state_e;

    localparam int DEF_DATA_W = 32;
    localparam int BE_W       = DEF_DATA_W / 8;

    // A request length of 0 means one beat; anything above the burst limit is cut down to it.
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned burst_max);
        if (len == 0) begin
            return 1;
        end
        if (len > burst_max) begin
            return burst_max;
        end
        return len;
    endfunction

endpackage

// File: rtl/main_memory_burst_if.sv
// Request / write-beat / read-beat bus between the cache controller (master)
// and the burst main memory (slave).
interface main_memory_burst_if
    import main_memory_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = 4
);
    logic                  req;
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [LEN_W-1:0]      len;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  wvalid;
    logic                  wready;
    logic                  ready;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  rlast;
    logic                  done;
    logic                  err;

    modport master (
        output req, we, addr, len, be, wdata, wvalid,
        input  wready, ready, rvalid, rdata, rlast, done, err
    );

    modport slave (
        input  req, we, addr, len, be, wdata, wvalid,
        output wready, ready, rvalid, rdata, rlast, done, err
    );
endinterface

// File: rtl/main_memory_burst_array.sv
// DEPTH x DATA_W word array with byte-lane writes and a registered read port.
// Contents power up as mem[i] = i and are never touched by reset.
module mem_array_be #(
    parameter int DEPTH  = 65536,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                re,
    input  logic                we,
    input  logic [IDX_W-1:0]    addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   q
);
    localparam int LANES = DATA_W / 8;

    typedef logic [DATA_W-1:0] word_t;
    typedef word_t mem_t [DEPTH];

    function automatic mem_t init_image();
        mem_t m;
        for (int i = 0; i < DEPTH; i++) begin
            m[i] = word_t'(i);
        end
        return m;
    endfunction

    mem_t  mem = init_image();
    word_t q_reg;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int j = 0; j < LANES; j++) begin
                if (be[j]) begin
                    mem[addr][j*8 +: 8] <= wdata[j*8 +: 8];
                end
            end
        end
    end

    // Only the output register is reset; the stored words survive a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (re) begin
            q_reg <= mem[addr];
        end
    end

    assign q = q_reg;
endmodule

// File: rtl/main_memory_burst.sv
// Behavioural burst main memory: fixed latency, 1..BURST_MAX beat read/write
// bursts with wrap-around addressing and an out-of-range error response.
module main_memory_burst
    import main_memory_pkg::*;
#(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 65536,
    parameter int LATENCY   = 8,
    parameter int BURST_MAX = 8,
    parameter int LEN_W     = $clog2(BURST_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    main_memory_burst_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    mem_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [ADDR_W-1:0] addr_reg, addr_next, addr_inc;
    logic [LEN_W-1:0]  beat_reg, beat_next;
    logic [LEN_W-1:0]  last_reg, last_next;
    logic              we_reg, we_next;
    logic              ready_reg, ready_next;
    logic              wready_reg, wready_next;
    logic              rvalid_reg, rvalid_next;
    logic              rlast_reg, rlast_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;
    logic              mem_re, mem_we;
    logic [DATA_W-1:0] rdata;

    assign addr_inc = (addr_reg == ADDR_W'(DEPTH - 1)) ? '0 : addr_reg + 1'b1;

    // addr_reg always points at the next word to be read or written; reads are
    // issued one cycle ahead because the array output is registered.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        addr_next   = addr_reg;
        beat_next   = beat_reg;
        last_next   = last_reg;
        we_next     = we_reg;
        wready_next = 1'b0;
        rvalid_next = 1'b0;
        rlast_next  = 1'b0;
        done_next   = 1'b0;
        err_next    = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (bus.req && ready_reg) begin
                    we_next    = bus.we;
                    addr_next  = bus.addr;
                    last_next  = LEN_W'(clamp_len(32'(bus.len), BURST_MAX) - 1);
                    beat_next  = '0;
                    cnt_next   = CNT_W'(LATENCY);
                    state_next = (32'(bus.addr) >= DEPTH) ? FIN : WAIT;
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    if (we_reg) begin
                        wready_next = 1'b1;
                        state_next  = WR;
                    end else begin
                        mem_re      = 1'b1;
                        rvalid_next = 1'b1;
                        rlast_next  = (last_reg == '0);
                        addr_next   = addr_inc;
                        state_next  = RD;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RD: begin
                if (beat_reg == last_reg) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    mem_re      = 1'b1;
                    rvalid_next = 1'b1;
                    rlast_next  = ((beat_reg + 1'b1) == last_reg);
                    addr_next   = addr_inc;
                    beat_next   = beat_reg + 1'b1;
                end
            end
            WR: begin
                wready_next = 1'b1;
                if (bus.wvalid && wready_reg) begin
                    mem_we    = 1'b1;
                    addr_next = addr_inc;
                    beat_next = beat_reg + 1'b1;
                    if (beat_reg == last_reg) begin
                        wready_next = 1'b0;
                        done_next   = 1'b1;
                        state_next  = IDLE;
                    end
                end
            end
            FIN: begin
                done_next  = 1'b1;
                err_next   = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        ready_next = (state_next == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            beat_reg   <= '0;
            last_reg   <= '0;
            we_reg     <= 1'b0;
            ready_reg  <= 1'b1;
            wready_reg <= 1'b0;
            rvalid_reg <= 1'b0;
            rlast_reg  <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            addr_reg   <= addr_next;
            beat_reg   <= beat_next;
            last_reg   <= last_next;
            we_reg     <= we_next;
            ready_reg  <= ready_next;
            wready_reg <= wready_next;
            rvalid_reg <= rvalid_next;
            rlast_reg  <= rlast_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    mem_array_be #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .re    (mem_re),
        .we    (mem_we),
        .addr  (addr_reg[IDX_W-1:0]),
        .be    (bus.be),
        .wdata (bus.wdata),
        .q     (rdata)
    );

    assign bus.ready  = ready_reg;
    assign bus.wready = wready_reg;
    assign bus.rvalid = rvalid_reg;
    assign bus.rlast  = rlast_reg;
    assign bus.rdata  = rdata;
    assign bus.done   = done_reg;
    assign bus.err    = err_reg;
endmodule
